// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory responder: FSM state codes, op codes, request record.
// Pure declarations; no timing or backpressure of its own.
package data_mem_ctrl_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE   = 2'd0,
        DMEM_WAIT   = 2'd1,
        DMEM_ACCESS = 2'd2
    } dmem_state_e;

    typedef enum logic [1:0] {
        DMEM_OP_RD  = 2'd0,
        DMEM_OP_WR  = 2'd1,
        DMEM_OP_ERR = 2'd2
    } dmem_op_e;

    typedef struct packed {
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdat;
        dmem_op_e          op;
    } dmem_req_t;

    // Both enables at once is an illegal request and is tagged for the error path.
    function automatic dmem_op_e decode_op(input logic rd, input logic wr);
        if (rd && wr) return DMEM_OP_ERR;
        if (wr)       return DMEM_OP_WR;
        return DMEM_OP_RD;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// MEM-stage RAM request bus: requester drives address/data/enables, responder returns data and status.
// Requester holds its request stable while mem_busy is high.
interface data_mem_ctrl_if;
    logic [31:0] ram_addr_mem;
    logic [31:0] ram_data_mem;
    logic        ram_read_enable;
    logic        ram_write_enable;
    logic [31:0] ram_data;
    logic        mem_ready;
    logic        mem_busy;
    logic        addr_err;

    modport master (
        output ram_addr_mem, ram_data_mem, ram_read_enable, ram_write_enable,
        input  ram_data, mem_ready, mem_busy, addr_err
    );

    modport slave (
        input  ram_addr_mem, ram_data_mem, ram_read_enable, ram_write_enable,
        output ram_data, mem_ready, mem_busy, addr_err
    );
endinterface

// File: rtl/data_mem_ctrl_dmem_array.sv
// Single-port synchronous word RAM; read data registered one edge after re, held otherwise.
// No backpressure: every we/re is serviced on the next clock edge.
module dmem_array #(
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdat,
    output logic [31:0]       rdat
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdat_q;

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdat;
        if (re) rdat_q   <= mem[idx];
    end

    assign rdat = rdat_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: one LW/SW at a time, mem_ready 1+WAIT_CYCLES cycles after the request edge.
// Stalls the pipeline with mem_busy from request until the access cycle.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH),
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    data_mem_ctrl_if.slave   mem_if
);

    localparam logic [31:0]      ADDR_LIMIT = 32'(DEPTH * 4);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic              zero_q, zero_d;

    dmem_req_t         in_req, cur_req;
    logic              any_en, fire, bad;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_rdat;

    assign any_en = mem_if.ram_read_enable | mem_if.ram_write_enable;

    always_comb begin
        in_req  = '{addr: mem_if.ram_addr_mem,
                    wdat: mem_if.ram_data_mem,
                    op:   decode_op(mem_if.ram_read_enable, mem_if.ram_write_enable)};
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;

        unique case (state_q)
            DMEM_IDLE: begin
                if (any_en) begin
                    if (in_req.op == DMEM_OP_ERR) begin
                        state_d = DMEM_ACCESS;
                    end else begin
                        req_d = in_req;
                        if (WAIT_CYCLES > 0) begin
                            state_d = DMEM_WAIT;
                            cnt_d   = WAIT_LOAD;
                        end else begin
                            state_d = DMEM_ACCESS;
                        end
                    end
                end
            end
            DMEM_WAIT: begin
                if (cnt_q == '0) state_d = DMEM_ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DMEM_ACCESS: state_d = DMEM_IDLE;
            default:     state_d = DMEM_IDLE;
        endcase

        // The array is touched on the edge that enters ACCESS so that registered
        // read data is already valid while mem_ready is high. From IDLE (zero wait
        // or error) the request is taken straight off the bus.
        cur_req = (state_q == DMEM_IDLE) ? in_req : req_q;
        fire    = (state_d == DMEM_ACCESS);
        bad     = (cur_req.op == DMEM_OP_ERR) || (cur_req.addr[1:0] != 2'b00) ||
                  (cur_req.addr >= ADDR_LIMIT);
        ram_idx = cur_req.addr[ADDR_W+1:2];
        ram_we  = fire && !bad && (cur_req.op == DMEM_OP_WR);
        ram_re  = fire && !bad && (cur_req.op == DMEM_OP_RD);

        rdy_d  = fire;
        err_d  = fire && bad;
        zero_d = zero_q;
        if (fire && bad)  zero_d = 1'b1;
        else if (ram_re)  zero_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DMEM_IDLE;
            cnt_q   <= '0;
            req_q   <= '{addr: '0, wdat: '0, op: DMEM_OP_RD};
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .idx  (ram_idx),
        .wdat (cur_req.wdat),
        .rdat (ram_rdat)
    );

    // RAM output register holds the last good read; zero_q masks it after reset or a bad request.
    assign mem_if.ram_data  = zero_q ? '0 : ram_rdat;
    assign mem_if.mem_ready = rdy_q;
    assign mem_if.addr_err  = err_q;
    assign mem_if.mem_busy  = ((state_q == DMEM_IDLE) && any_en) || (state_q == DMEM_WAIT);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: a WAIT_CYCLES=2 instance (table, reset, random) and a zero-wait instance.
module tb_data_mem_ctrl;

    localparam int WA    = 2;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    data_mem_ctrl_if a_if();
    data_mem_ctrl_if z_if();

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WA)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .mem_if  (a_if)
    );

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk     (clk),
        .reset_n (reset_n),
        .mem_if  (z_if)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] model [logic [31:0]];
    logic [31:0] keys [$];
    logic [31:0] last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdat, output int ready_cyc, output int busy_cnt,
                         output logic [31:0] rdat, output logic err);
        ready_cyc = -1;
        busy_cnt  = 0;
        rdat      = '0;
        err       = 1'b0;
        @(posedge clk); #1;
        a_if.ram_read_enable  = rd;
        a_if.ram_write_enable = wr;
        a_if.ram_addr_mem     = addr;
        a_if.ram_data_mem     = wdat;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (a_if.mem_busy) busy_cnt++;
            if (a_if.mem_ready) begin
                ready_cyc = c;
                rdat      = a_if.ram_data;
                err       = a_if.addr_err;
                break;
            end
        end
        @(posedge clk); #1;
        a_if.ram_read_enable  = 1'b0;
        a_if.ram_write_enable = 1'b0;
    endtask

    task automatic do_chk_a(input string tag, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wdat,
                            input logic [31:0] exp_data, input logic exp_err);
        int          rc, bc, exp_lat;
        logic [31:0] rdat;
        logic        err;
        exp_lat = (rd && wr) ? 1 : 1 + WA;
        run_a(rd, wr, addr, wdat, rc, bc, rdat, err);
        chk({tag, "_ready_cycle"}, 32'(rc), 32'(exp_lat));
        chk({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
        chk({tag, "_data"}, rdat, exp_data);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        if (!model.exists(a)) keys.push_back(a);
        model[a] = d;
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{1'b0, 1'b1, 32'h20,   32'hDEADBEEF, 32'h11111111, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h20,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h22,   32'h0,        32'h0,        1'b1};
        tbl[3]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
        tbl[4]  = '{1'b1, 1'b0, 32'h20,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 32'h0,    32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h0,    32'hFFFFFFFF, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 1'b0, 32'h0,    32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'hFFC,  32'h12345678, 32'hA5A5A5A5, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 32'hFFC,  32'h0,        32'h12345678, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 32'h0,    32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 32'h23,   32'h0,        32'h0,        1'b1};
        tbl[12] = '{1'b1, 1'b0, 32'h20,   32'h0,        32'hDEADBEEF, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 32'h1000, 32'h0,        32'h0,        1'b1};
        tbl[14] = '{1'b1, 1'b0, 32'h0,    32'h0,        32'hA5A5A5A5, 1'b0};

        a_if.ram_read_enable = 1'b0; a_if.ram_write_enable = 1'b0;
        a_if.ram_addr_mem    = '0;   a_if.ram_data_mem     = '0;
        z_if.ram_read_enable = 1'b0; z_if.ram_write_enable = 1'b0;
        z_if.ram_addr_mem    = '0;   z_if.ram_data_mem     = '0;
        reset_n = 1'b0;
        #1;
        chk("reset_ram_data", a_if.ram_data, 32'h0);
        chk("reset_ready", {31'b0, a_if.mem_ready}, 32'h0);
        chk("reset_err", {31'b0, a_if.addr_err}, 32'h0);
        chk("reset_busy", {31'b0, a_if.mem_busy}, 32'h0);
        #20 reset_n = 1'b1;

        // Reset in the middle of a store's wait phase must abandon the store.
        do_chk_a("pre_sw10", 1'b0, 1'b1, 32'h10, 32'h11111111, 32'h0, 1'b0);
        do_chk_a("pre_lw10", 1'b1, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b0);
        model_write(32'h10, 32'h11111111);
        @(posedge clk); #1;
        a_if.ram_write_enable = 1'b1;
        a_if.ram_addr_mem     = 32'h10;
        a_if.ram_data_mem     = 32'h22222222;
        @(negedge clk);
        @(negedge clk);
        chk("rst_wait_busy", {31'b0, a_if.mem_busy}, 32'h1);
        reset_n = 1'b0;
        a_if.ram_write_enable = 1'b0;
        #1;
        chk("rst_mid_ram_data", a_if.ram_data, 32'h0);
        chk("rst_mid_ready", {31'b0, a_if.mem_ready}, 32'h0);
        chk("rst_mid_err", {31'b0, a_if.addr_err}, 32'h0);
        chk("rst_mid_busy", {31'b0, a_if.mem_busy}, 32'h0);
        @(negedge clk); #2;
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (a_if.mem_ready || a_if.mem_busy) cnt++;
        end
        chk("rst_idle_after", 32'(cnt), 32'h0);
        do_chk_a("rst_lw10", 1'b1, 1'b0, 32'h10, 32'h0, 32'h11111111, 1'b0);

        for (int i = 0; i < 15; i++) begin
            do_chk_a($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].addr,
                     tbl[i].wdat, tbl[i].exp_data, tbl[i].exp_err);
            if (tbl[i].wr && !tbl[i].rd && !tbl[i].exp_err) model_write(tbl[i].addr, tbl[i].wdat);
            last_data = tbl[i].exp_data;
        end

        // Zero-wait instance: one store, then a load held for two back-to-back accesses.
        @(posedge clk); #1;
        z_if.ram_write_enable = 1'b1;
        z_if.ram_addr_mem     = 32'h40;
        z_if.ram_data_mem     = 32'hCAFEF00D;
        @(negedge clk);
        chk("z_sw_c0_busy", {31'b0, z_if.mem_busy}, 32'h1);
        chk("z_sw_c0_ready", {31'b0, z_if.mem_ready}, 32'h0);
        @(negedge clk);
        chk("z_sw_c1_ready", {31'b0, z_if.mem_ready}, 32'h1);
        chk("z_sw_c1_busy", {31'b0, z_if.mem_busy}, 32'h0);
        chk("z_sw_c1_err", {31'b0, z_if.addr_err}, 32'h0);
        @(posedge clk); #1;
        z_if.ram_write_enable = 1'b0;
        z_if.ram_read_enable  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("z_lw_c%0d_busy", c), {31'b0, z_if.mem_busy}, (c % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("z_lw_c%0d_ready", c), {31'b0, z_if.mem_ready}, (c % 2 == 1) ? 32'h1 : 32'h0);
            if (c % 2 == 1) chk($sformatf("z_lw_c%0d_data", c), z_if.ram_data, 32'hCAFEF00D);
        end
        @(posedge clk); #1;
        z_if.ram_read_enable = 1'b0;

        for (int i = 0; i < 150; i++) begin
            int unsigned r;
            logic [31:0] a, d;
            r = $urandom_range(0, 9);
            d = $urandom;
            if (r <= 3) begin
                a = {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
                do_chk_a($sformatf("rnd%0d_sw", i), 1'b0, 1'b1, a, d, last_data, 1'b0);
                model_write(a, d);
            end else if (r <= 7) begin
                a = keys[$urandom_range(0, keys.size() - 1)];
                last_data = model[a];
                do_chk_a($sformatf("rnd%0d_lw", i), 1'b1, 1'b0, a, 32'h0, last_data, 1'b0);
            end else if (r == 8) begin
                a = {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
                last_data = 32'h0;
                if ($urandom_range(0, 1) == 1)
                    do_chk_a($sformatf("rnd%0d_mis_lw", i), 1'b1, 1'b0, a, d, 32'h0, 1'b1);
                else
                    do_chk_a($sformatf("rnd%0d_mis_sw", i), 1'b0, 1'b1, a, d, 32'h0, 1'b1);
            end else begin
                last_data = 32'h0;
                if ($urandom_range(0, 1) == 1) begin
                    a = 32'($urandom_range(DEPTH * 4, 32'hFFFF_FFFF));
                    do_chk_a($sformatf("rnd%0d_oor_sw", i), 1'b0, 1'b1, a, d, 32'h0, 1'b1);
                end else begin
                    a = {20'b0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
                    do_chk_a($sformatf("rnd%0d_both", i), 1'b1, 1'b1, a, d, 32'h0, 1'b1);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
